undo_ctrl: RTL
==============

# undo_ctrl

Controller for the AXA undo stack: owns the 16-entry LIFO of overwritten register values and arbitrates between the ALU stage, which pushes old destination values, and the register-read stage, which pops values for `SRC_UNDO` operands. It replaces the enable-strobed stack with a registered request/acknowledge protocol. Its policies are fixed round-robin arbitration, overwrite-oldest on full and flagged underflow on empty.

## Interface
- `DEPTH`, 16: number of stack entries; power of two, at least 2.
- `WIDTH`, 16: data word width.
- `clk` input 1: the single clock; all state changes on posedge.
- `reset` input 1: synchronous, active-high reset.
- `clr` input 1: synchronous flush; empties the stack, as on pipeline restart.
- `push_req` input 1: ALU-stage push request; held until `push_ack` is seen.
- `push_data` input WIDTH: value to push; must be stable while `push_req` is high.
- `push_ack` output 1: one-cycle pulse, push committed.
- `pop_req` input 1: register-read-stage pop request; held until `pop_ack` is seen.
- `pop_ack` output 1: one-cycle pulse, pop completed; `pop_data` is valid in the same cycle.
- `pop_data` output WIDTH: popped value; held until the next `pop_ack`.
- `pop_err` output 1: high with `pop_ack` when the pop hit an empty stack.
- `count` output clog2(DEPTH)+1: current number of valid entries.
- `full`, `empty` output 1: `count==DEPTH` and `count==0`; combinational from `count`.
- `ovf_flag`, `unf_flag` output 1: sticky overflow and underflow flags; cleared only by `reset`.
- `peek_idx` input clog2(DEPTH): depth below the top of stack; 0 is the top.
- `peek_data` output WIDTH: registered peek result.

## Operation
- Storage is a circular array indexed by `top` (clog2(DEPTH) bits), which wraps modulo DEPTH.
- `count` saturates at DEPTH.
- **Push:** write `mem[top+1]`, then `top <= top+1`.
  - If the stack was not full, `count` increments.
  - If the stack was full, the oldest entry is silently overwritten, `count` stays at DEPTH and `ovf_flag` is set.
- **Pop, stack not empty:** `pop_data <= mem[top]`, `top <= top-1`, `count` decrements.
- **Pop, stack empty:** `pop_data <= 0`, `pop_err=1`, `unf_flag` is set, and `top` and `count` are unchanged.
- **Grant eligibility:** a port is eligible when its request is high and its ack is not high in the same cycle. This gap prevents a held request from being double-counted.
- **Arbitration:** when only one port is eligible, it is granted. When both are eligible, the grant goes to the port not granted last. The `last` register resets to `POP`, so push wins the first conflict after reset.
- Exactly one operation is committed per cycle; the losing port stays pending.
- **`clr`:** sets `top` and `count` to 0, grants nothing that cycle, asserts no ack, and leaves requests pending. It does not change the flags or `last`.
- **Arbiter state:** `IDLE` (no grant), `GPUSH` and `GPOP`. Each grant state lasts exactly one cycle.
  - From `GPUSH`: go to `GPOP` if pop is eligible, otherwise to `IDLE`. Push cannot be re-granted immediately.
  - From `GPOP`: symmetric to `GPUSH`.
  - From `IDLE`: apply the arbitration rule.
  - `clr` or `reset` forces `IDLE`.
- **Values after reset:**
  - `push_ack=0`, `pop_ack=0`, `pop_err=0`.
  - `pop_data=0`, `peek_data=0`.
  - `count=0`, `empty=1`, `full=0`.
  - `ovf_flag=0`, `unf_flag=0`.
  - Memory contents are not cleared.

## Timing
- The request is sampled at posedge N. The operation is committed and the ack is high during cycle N+1, one cycle of latency.
- `pop_data` and `pop_err` become valid together with `pop_ack`.
- The requester deasserts its request at the posedge where it samples the ack high.
- Sustained throughput is one operation per cycle total and one operation per two cycles per port.
- `count`, `full` and `empty` reflect the committed operation from cycle N+1 onward.
- `reset` asserted during a pending or acked transaction: the ack drops in the next cycle, the operation in flight at that edge is not committed and the FSM returns to `IDLE`.
- Simultaneous `reset` and `clr`: `reset` dominates.

## Configuration
- Macro `UNDO_CTRL_PEEK_EN`.
- **Defined:** `peek_data <= mem[top - peek_idx]` every cycle, one cycle of latency, read-only.
  - Reading at or beyond `count` returns the stale array contents; no error is raised.
  - A same-cycle push or pop is not forwarded: the peek sees `top` from before the commit.
- **Undefined:** `peek_idx` is ignored and `peek_data` is tied to 0. No peek logic is synthesized.

## Test plan
- **Push then pop:** reset, then push 0x1234, 0xABCD, 0x0001, each held until ack.
  - After the pushes: `count=3`.
  - Then three pops return 0x0001, 0xABCD, 0x1234, in that order, each with `pop_err=0`.
  - At the end: `empty=1`.
- **Conflict:** push 0x00AA and pop requested in the same cycle on a stack holding 0x0055.
  - Push is acked first.
  - The pop is acked one cycle later and returns 0x00AA.
- **Round-robin fairness:** keep both requests continuously re-asserted for 8 cycles.
  - Acks alternate push, pop, push, pop.
  - `count` oscillates between its start value and start+1.
- **Overflow:** push 17 values, 0x0000 through 0x0010.
  - `count=16` and `full=1`; `ovf_flag=1` after the 17th push.
  - 16 pops return 0x0010 down to 0x0001; 0x0000 is lost.
- **Underflow:** pop on an empty stack.
  - The ack arrives with `pop_err=1`, `pop_data=0` and `unf_flag=1`.
  - `count` stays 0.
  - A subsequent push of 0x0007 followed by a pop returns 0x0007.
- **Mid-operation flush and peek:** 3 values pushed, then `clr` asserted in the same cycle as `pop_req`.
  - No ack that cycle.
  - The following pop is acked with `pop_err=1`.
  - With `UNDO_CTRL_PEEK_EN` defined, before the `clr`: `peek_idx=2` returns the first-pushed value.

Source files
------------

// File: rtl/undo_if.sv
// Request/acknowledge bundle between the undo-stack controller and its two clients:
// the ALU stage (push side) and the register-read stage (pop side).
interface undo_if #(
  parameter int WIDTH = 16
);
  logic             push_req;
  logic [WIDTH-1:0] push_data;
  logic             push_ack;
  logic             pop_req;
  logic             pop_ack;
  logic [WIDTH-1:0] pop_data;
  logic             pop_err;

  modport master (
    output push_req, push_data, pop_req,
    input  push_ack, pop_ack, pop_data, pop_err
  );

  modport slave (
    input  push_req, push_data, pop_req,
    output push_ack, pop_ack, pop_data, pop_err
  );
endinterface

// File: rtl/undo_ctrl.sv
// Undo-stack controller: circular LIFO with round-robin push/pop arbitration,
// overwrite-oldest on full, flagged underflow on empty. Optional peek port: UNDO_CTRL_PEEK_EN.
module undo_ctrl #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  undo_if.slave                   bus,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    ovf_flag,
  output logic                    unf_flag,
  input  logic [$clog2(DEPTH)-1:0] peek_idx,
  output logic [WIDTH-1:0]        peek_data
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GPUSH = 2'd1,
    GPOP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             last_pop;
  logic [AW-1:0]    top;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_elig;
  logic             pop_elig;
  logic             do_push;
  logic             do_pop;
  logic             pop_err_r;
  logic [WIDTH-1:0] pop_data_r;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A request seen together with its own ack is the tail of the previous grant.
  assign push_elig = bus.push_req && !bus.push_ack;
  assign pop_elig  = bus.pop_req  && !bus.pop_ack;

  always_comb begin
    state_nx = IDLE;
    case (state)
      GPUSH: state_nx = pop_elig  ? GPOP  : IDLE;
      GPOP:  state_nx = push_elig ? GPUSH : IDLE;
      default: begin
        if (push_elig && pop_elig) begin
          state_nx = last_pop ? GPUSH : GPOP;
        end else if (push_elig) begin
          state_nx = GPUSH;
        end else if (pop_elig) begin
          state_nx = GPOP;
        end
      end
    endcase
    if (clr) begin
      state_nx = IDLE;
    end
  end

  // The commit happens on the edge that enters the grant state; the ack follows.
  assign do_push = (state_nx == GPUSH) && !reset;
  assign do_pop  = (state_nx == GPOP)  && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_pop <= 1'b1;
    end else begin
      state <= state_nx;
      if (do_push) begin
        last_pop <= 1'b0;
      end else if (do_pop) begin
        last_pop <= 1'b1;
      end
    end
  end

  assign bus.push_ack = (state == GPUSH);
  assign bus.pop_ack  = (state == GPOP);
  assign bus.pop_err  = pop_err_r;
  assign bus.pop_data = pop_data_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      top       <= '0;
      count     <= '0;
      ovf_flag  <= 1'b0;
      unf_flag  <= 1'b0;
      pop_err_r <= 1'b0;
    end else if (clr) begin
      top       <= '0;
      count     <= '0;
      pop_err_r <= 1'b0;
    end else begin
      pop_err_r <= 1'b0;
      if (do_push) begin
        top <= top + 1'b1;
        if (full) begin
          ovf_flag <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end else if (do_pop) begin
        if (empty) begin
          pop_err_r <= 1'b1;
          unf_flag  <= 1'b1;
        end else begin
          top   <= top - 1'b1;
          count <= count - 1'b1;
        end
      end
    end
  end

  // Storage array is never reset; only the pop result register is.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[top + 1'b1] <= bus.push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_data_r <= '0;
    end else if (do_pop) begin
      pop_data_r <= empty ? '0 : mem[top];
    end
  end

`ifdef UNDO_CTRL_PEEK_EN
  // Peek uses the pre-commit top; same-cycle pushes/pops are not forwarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      peek_data <= '0;
    end else begin
      peek_data <= mem[top - peek_idx];
    end
  end
`else
  logic unused_peek;
  assign unused_peek = ^peek_idx;
  assign peek_data   = '0;
`endif

  a_ack_onehot: assert property (@(posedge clk) disable iff (reset)
    !(bus.push_ack && bus.pop_ack));
  a_count_range: assert property (@(posedge clk) disable iff (reset)
    count <= CNT_W'(DEPTH));

endmodule
